// File: rtl/imem_fetch_port.sv
// rtl/imem_fetch_port.sv - instruction memory with ready/valid fetch port and byte-enabled load port
// Optional per-byte even parity is enabled by defining IMEM_PARITY_EN.
module imem_fetch_port #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 2048
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fetch_req,
   input  logic [ADDR_WIDTH-1:0]     fetch_addr,
   output logic                      fetch_ready,
   output logic                      fetch_valid,
   output logic [DATA_WIDTH-1:0]     fetch_data,
   output logic                      fetch_err,
   input  logic                      fetch_accept,
   input  logic                      load_en,
   input  logic [ADDR_WIDTH-1:0]     load_addr,
   input  logic [DATA_WIDTH-1:0]     load_data,
   input  logic [DATA_WIDTH/8-1:0]   load_be,
   output logic                      load_ack,
   output logic                      load_err,
   output logic                      parity_err
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic          issue;
   logic          fetch_in_range;
   logic          load_in_range;
   logic [IW-1:0] fetch_idx;
   logic [IW-1:0] load_idx;

   // Full-width compare: addresses at or beyond DEPTH never alias into the array.
   assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_W);
   assign load_in_range  = ({1'b0, load_addr} < DEPTH_W);
   assign fetch_idx      = fetch_addr[IW-1:0];
   assign load_idx       = load_addr[IW-1:0];

   // Load owns the cycle; fetch only proceeds when the output slot is free or being drained.
   assign fetch_ready = !rst && !load_en && (!fetch_valid || fetch_accept);
   assign issue       = fetch_req && fetch_ready;

`ifdef IMEM_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];
`endif

   always_ff @(posedge clk) begin
      if (load_en && load_in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (load_be[i]) begin
               mem[load_idx][8*i +: 8] <= load_data[8*i +: 8];
`ifdef IMEM_PARITY_EN
               par_mem[load_idx][i] <= ^load_data[8*i +: 8];
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_valid <= 1'b0;
         fetch_data  <= '0;
         fetch_err   <= 1'b0;
      end else if (issue) begin
         fetch_valid <= 1'b1;
         fetch_err   <= !fetch_in_range;
         fetch_data  <= fetch_in_range ? mem[fetch_idx] : '0;
      end else if (fetch_accept) begin
         fetch_valid <= 1'b0;
      end
   end

`ifdef IMEM_PARITY_EN
   logic [DATA_WIDTH-1:0] rd_word;
   logic [NB-1:0]         rd_par;
   logic [NB-1:0]         par_bad;

   always_comb begin
      rd_word = mem[fetch_idx];
      rd_par  = par_mem[fetch_idx];
      par_bad = '0;
      for (int i = 0; i < NB; i++) begin
         par_bad[i] = (^rd_word[8*i +: 8]) ^ rd_par[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err <= 1'b0;
      end else if (issue) begin
         parity_err <= fetch_in_range && (|par_bad);
      end
   end
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_ack <= 1'b0;
         load_err <= 1'b0;
      end else begin
         load_ack <= load_en;
         load_err <= load_en && !load_in_range;
      end
   end

endmodule

// File: tb/tb_imem_fetch_port.sv
// tb/tb_imem_fetch_port.sv - randomized self-checking bench for imem_fetch_port
// Reference model: word array plus an in-order queue of expected fetch results.
module tb_imem_fetch_port;

   localparam int DEPTH = 2048;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] fetch_data;
   logic        fetch_err;
   logic        fetch_accept;
   logic        load_en;
   logic [15:0] load_addr;
   logic [31:0] load_data;
   logic [3:0]  load_be;
   logic        load_ack;
   logic        load_err;
   logic        parity_err;

   imem_fetch_port dut (
      .clk          (clk),
      .rst          (rst),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_ready  (fetch_ready),
      .fetch_valid  (fetch_valid),
      .fetch_data   (fetch_data),
      .fetch_err    (fetch_err),
      .fetch_accept (fetch_accept),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_be      (load_be),
      .load_ack     (load_ack),
      .load_err     (load_err),
      .parity_err   (parity_err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] ref_mem [DEPTH];
   logic [32:0] exp_q [$];
   logic        exp_ack  = 1'b0;
   logic        exp_lerr = 1'b0;
   logic        issued;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // One clock cycle: drive, compare against the model, advance the model, cross the edge.
   task automatic step(input logic req, input logic [15:0] fa, input logic acc,
                       input logic le, input logic [15:0] la, input logic [31:0] ld,
                       input logic [3:0] lb);
      logic exp_ready;
      fetch_req    = req;
      fetch_addr   = fa;
      fetch_accept = acc;
      load_en      = le;
      load_addr    = la;
      load_data    = ld;
      load_be      = lb;
      #1;
      exp_ready = !le && (exp_q.size() == 0 || acc);
      check("fetch_ready", fetch_ready, exp_ready);
      check("fetch_valid", fetch_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         check("fetch_data", fetch_data, exp_q[0][31:0]);
         check("fetch_err", fetch_err, exp_q[0][32]);
         check("parity_err", parity_err, 1'b0);
      end
      check("load_ack", load_ack, exp_ack);
      check("load_err", load_err, exp_lerr);
      if (exp_q.size() != 0 && acc) void'(exp_q.pop_front());
      issued = req && exp_ready;
      if (issued) begin
         if (fa < DEPTH) exp_q.push_back({1'b0, ref_mem[fa[10:0]]});
         else            exp_q.push_back({1'b1, 32'h0});
      end
      exp_ack  = le;
      exp_lerr = le && (la >= DEPTH);
      if (le && la < DEPTH) begin
         for (int b = 0; b < 4; b++)
            if (lb[b]) ref_mem[la[10:0]][8*b +: 8] = ld[8*b +: 8];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4, 5: return 16'($urandom_range(0, 31));
         6, 7:             return 16'(2040 + $urandom_range(0, 7));
         8:                return 16'(2048 + $urandom_range(0, 3));
         default:          return 16'($urandom_range(2048, 65535));
      endcase
   endfunction

   initial begin
      logic [15:0] na;
      int          guard;
      rst = 1'b1; fetch_req = 0; fetch_addr = 0; fetch_accept = 0;
      load_en = 0; load_addr = 0; load_data = 0; load_be = 0;
      #2;
      check("rst_ready", fetch_ready, 1'b0);
      check("rst_valid", fetch_valid, 1'b0);
      check("rst_data", fetch_data, 32'h0);
      check("rst_err", fetch_err, 1'b0);
      check("rst_ack", load_ack, 1'b0);
      check("rst_lerr", load_err, 1'b0);
      check("rst_parity", parity_err, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int a = 0; a < 32; a++)
         step(1'b0, 16'h0, 1'b1, 1'b1, 16'(a), $urandom, 4'hF);
      for (int a = 2040; a < 2048; a++)
         step(1'b0, 16'h0, 1'b1, 1'b1, 16'(a), $urandom, 4'hF);
      idle();

      // Basic load then fetch
      step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 32'h12345678, 4'hF);
      step(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
      check("basic_data", fetch_data, 32'h12345678);
      check("basic_err", fetch_err, 1'b0);
      idle();

      // Byte-enable merge
      step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0003, 32'hAABBCCDD, 4'hF);
      step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0003, 32'h11223344, 4'b0101);
      step(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
      check("be_merge", fetch_data, 32'hAA22CC44);
      idle();

      // Backpressure: words 0..3 with accept held low for 3 cycles after the first result
      na = 16'h0;
      step(1'b1, na, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
      if (issued) na++;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, na, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
         check("bp_no_issue", issued, 1'b0);
      end
      guard = 0;
      while (na < 4 && guard < 20) begin
         step(1'b1, na, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
         if (issued) na++;
         guard++;
      end
      check("bp_all_issued", na, 16'd4);
      idle();

      // Arbitration: load wins for two cycles, fetch issues on the third
      step(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0006, 32'hCAFE0001, 4'hF);
      check("arb_blocked0", issued, 1'b0);
      step(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0007, 32'hCAFE0002, 4'hF);
      check("arb_blocked1", issued, 1'b0);
      step(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
      check("arb_issue", issued, 1'b1);
      idle();

      // Out of range fetch and load; last in-range word untouched
      step(1'b1, 16'h0800, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
      check("oor_data", fetch_data, 32'h0);
      check("oor_err", fetch_err, 1'b1);
      step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0FFF, 32'hDEADBEEF, 4'hF);
      check("oor_lerr", load_err, 1'b1);
      step(1'b1, 16'h07FF, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
      idle();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) != 0, pick_addr(), $urandom_range(0, 9) < 7,
              $urandom_range(0, 4) == 0, pick_addr(), $urandom, 4'($urandom));
      end

      // Asynchronous reset with a held result
      step(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
      check("pre_rst_valid", fetch_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", fetch_valid, 1'b0);
      check("async_rst_data", fetch_data, 32'h0);
      check("async_rst_ready", fetch_ready, 1'b0);
      exp_q.delete();
      exp_ack  = 1'b0;
      exp_lerr = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      step(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
      idle();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised instruction memory with a ready/valid fetch port and a byte-enabled program-load port. It replaces the fixed 2048×32 instruction store in front of the fetch stage. It adds:
- backpressure from fetch;
- load-over-fetch arbitration;
- out-of-range detection;
- optional per-byte parity.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, word-address width.
- DEPTH, 2048, number of words; DEPTH ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_WIDTH  fetch word address.
- fetch_ready  out  1  request accepted this cycle when high with fetch_req.
- fetch_valid  out  1  fetch_data/fetch_err hold a result.
- fetch_data  out  DATA_WIDTH  fetched word.
- fetch_err  out  1  result came from an out-of-range address.
- fetch_accept  in  1  consumer takes the result this cycle.
- load_en  in  1  program-load write strobe.
- load_addr  in  ADDR_WIDTH  load word address.
- load_data  in  DATA_WIDTH  load word.
- load_be  in  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i].
- load_ack  out  1  one-cycle pulse, load completed.
- load_err  out  1  one-cycle pulse with load_ack, load address out of range.
- parity_err  out  1  parity mismatch on the current result; see Configuration.

## Operation
- Array: DEPTH words, no reset of contents.
- fetch_ready = !rst && !load_en && (!fetch_valid || fetch_accept). This is combinational; no combinational path from fetch_req.
- Fetch issue happens when fetch_req && fetch_ready.
  - In range (fetch_addr < DEPTH): the array is read and the word lands in the fetch_data register next edge. fetch_err = 0.
  - Out of range: the array is not accessed. fetch_data = 0, fetch_err = 1.
- Output register states:
  - EMPTY (fetch_valid=0) -> FULL on issue.
  - FULL -> FULL on (accept && issue), which loads a new result.
  - FULL -> EMPTY on (accept && !issue).
  - FULL holds data/err unchanged while !fetch_accept.
- Load: on load_en, bytes with load_be=1 are written at load_addr and bytes with load_be=0 keep their old value.
  - Out-of-range load: no write; load_err pulses.
  - load_ack pulses the next cycle for every load_en cycle, including back-to-back loads.
- Arbitration: load always wins. Fetch is blocked (fetch_ready=0) in any cycle with load_en. The held fetch result is unaffected. No same-cycle read/write collision is possible.
- fetch_accept while fetch_valid=0 is ignored.

## Timing
- Fetch latency: issue at edge N gives fetch_valid=1 after edge N. Sustained throughput is 1 word/cycle with fetch_accept held high.
- Load latency: write occurs at edge N. load_ack/load_err are high for the cycle after edge N. A fetch issued at edge N+1 to the same address returns the new data.
- Reset values: fetch_valid=0, fetch_data=0, fetch_err=0, load_ack=0, load_err=0, parity_err=0, fetch_ready=0 while rst is high.
- Reset mid-operation: any in-flight result is discarded. Array contents are retained but unspecified for verification.
- Address compare: full ADDR_WIDTH compare against DEPTH. There is no wrap-around or aliasing.

## Configuration
- Macro IMEM_PARITY_EN.
- Defined:
  - Each byte stores an even-parity bit, written only with its byte enable.
  - On every in-range fetch, all DATA_WIDTH/8 parity bits are checked.
  - parity_err is registered with fetch_data and follows the same FULL/hold rules.
  - Out-of-range fetches give parity_err = 0.
  - A never-written byte returns an undefined parity_err.
- Not defined: no parity storage or check logic; parity_err tied to 0.

## Test plan
- Basic load/fetch:
  - Stimulus: reset; load 0x12345678 at 0x0010, be=4'hF; fetch 0x0010 the cycle after load_ack.
  - Required: fetch_valid with fetch_data=0x12345678, fetch_err=0.
- Byte enables:
  - Stimulus: load 0xAABBCCDD at 0x0003 be=4'hF, then 0x11223344 be=4'b0101.
  - Required: fetch returns 0xAA22CC44.
- Backpressure:
  - Stimulus: stream fetches 0..3 with fetch_accept low for 3 cycles after the first result.
  - Required: fetch_data holds word 0 and fetch_ready=0 for those 3 cycles. Words 0..3 are delivered in order with none lost or duplicated.
- Arbitration:
  - Stimulus: assert fetch_req and load_en together for 2 cycles.
  - Required: fetch_ready=0 both cycles; two load_ack pulses; the fetch issues on the third cycle.
- Out-of-range:
  - Stimulus: DEPTH=2048; fetch 0x0800 and load 0x0FFF.
  - Required: fetch_data=0 with fetch_err=1; load_ack with load_err=1; word 0x07FF unchanged.
- Reset and parity:
  - Reset: assert rst while fetch_valid=1; required fetch_valid=0 immediately (asynchronous).
  - Parity: with IMEM_PARITY_EN, force-flip one stored data bit; required parity_err=1 on its fetch.
